// File: rtl/operand_fetch_unit.sv
// Decode/operand-read stage: decodes fields, reads the GPR file, forwards or stalls on RAW hazards.
// Latency: 1 cycle from accept (in_valid && in_ready) to out_valid; bubbles (opcode 0) otherwise.
// Backpressure: in_ready drops for one cycle on a hazard and permanently after HALT; flush forces in_ready=1.
// Build option: OPERAND_FORWARD_EN enables the execute-result bypass; when undefined, any execute-stage
// register producer matching a used source stalls one cycle instead. The writeback bypass is always present.
module operand_fetch_unit #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 10,
    parameter int GPR_COUNT  = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [31:0]           instruction,
    input  logic [ADDR_WIDTH-1:0] pc_in,
    input  logic                  flush,
    input  logic [2:0]            ex_dest,
    input  logic [DATA_WIDTH-1:0] ex_result,
    input  logic                  ex_wb_reg,
    input  logic                  ex_read,
    input  logic                  wb_en,
    input  logic [2:0]            wb_dest,
    input  logic [DATA_WIDTH-1:0] wb_data,
    output logic                  out_valid,
    output logic [6:0]            opcode,
    output logic [2:0]            dest,
    output logic [DATA_WIDTH-1:0] operand0,
    output logic [DATA_WIDTH-1:0] operand1,
    output logic [DATA_WIDTH-1:0] operand2,
    output logic [3:0]            value,
    output logic [7:0]            constant,
    output logic [9:0]            offset,
    output logic [2:0]            condition,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic                  halted
);

    typedef struct packed {
        logic [6:0] opcode;
        logic [2:0] cond;
        logic [2:0] r0;
        logic [2:0] r1;
        logic [2:0] r2;
        logic [2:0] rsvd;
        logic [9:0] offset;   // constant and value are the low 8 / 4 bits of this field
    } instr_t;

    typedef enum logic [2:0] {
        CLS_NOP   = 3'b000,
        CLS_ARITH = 3'b001,
        CLS_LOGIC = 3'b010,
        CLS_SHIFT = 3'b011,
        CLS_MEM   = 3'b100,
        CLS_JUMP  = 3'b101,
        CLS_JCOND = 3'b110,
        CLS_HALT  = 3'b111
    } cls_t;

    instr_t                fi;
    cls_t                  cls;
    logic [DATA_WIDTH-1:0] gpr [GPR_COUNT];
    logic [2:0]            src_idx [3];
    logic [DATA_WIDTH-1:0] src_val [3];
    logic [2:0]            src_use;
    logic [2:0]            src_haz;
    logic                  hazard;
    logic                  issue;
    logic                  unused_bits;

    assign fi          = instruction;
    assign cls         = cls_t'(fi.opcode[6:4]);
    assign unused_bits = ^fi.rsvd;

    // Which register fields each instruction class actually consumes.
    always_comb begin
        src_use = 3'b000;
        unique case (cls)
            CLS_ARITH, CLS_LOGIC: src_use = 3'b110;
            CLS_SHIFT:            src_use = 3'b010;
            CLS_MEM:              src_use = 3'b011;
            CLS_JUMP:             src_use = 3'b001;
            CLS_JCOND:            src_use = 3'b011;
            default:              src_use = 3'b000;
        endcase
    end

    // Per-source operand select (execute bypass, then writeback bypass, then GPR) and hazard detection.
    always_comb begin
        src_idx[0] = fi.r0;
        src_idx[1] = fi.r1;
        src_idx[2] = fi.r2;
        src_haz    = 3'b000;
        for (int s = 0; s < 3; s++) begin
            src_val[s] = gpr[src_idx[s]];
            if (wb_en && wb_dest == src_idx[s])
                src_val[s] = wb_data;
`ifdef OPERAND_FORWARD_EN
            if (ex_wb_reg && ex_dest == src_idx[s])
                src_val[s] = ex_result;
            src_haz[s] = src_use[s] && ex_read && (ex_dest == src_idx[s]);
`else
            src_haz[s] = src_use[s] && (ex_read || ex_wb_reg) && (ex_dest == src_idx[s]);
`endif
        end
    end

    assign hazard   = in_valid && (|src_haz);
    assign issue    = in_valid && !flush && !halted && !hazard;
    // Flush overrides everything so fetch can drop its instruction; otherwise halt and hazards block.
    assign in_ready = reset && (flush || (!halted && !hazard));

    // GPR file write port, owned by writeback.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < GPR_COUNT; i++) gpr[i] <= '0;
        end else if (wb_en) begin
            gpr[wb_dest] <= wb_data;
        end
    end

    // Execute-side pipeline register: issued instruction or an all-zero bubble.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset || !issue) begin
            out_valid <= 1'b0;
            opcode    <= '0;
            dest      <= '0;
            operand0  <= '0;
            operand1  <= '0;
            operand2  <= '0;
            value     <= '0;
            constant  <= '0;
            offset    <= '0;
            condition <= '0;
            pc        <= '0;
        end else begin
            out_valid <= 1'b1;
            opcode    <= fi.opcode;
            dest      <= fi.r0;
            operand0  <= src_val[0];
            operand1  <= src_val[1];
            operand2  <= src_val[2];
            value     <= fi.offset[3:0];
            constant  <= fi.offset[7:0];
            offset    <= fi.offset;
            condition <= fi.cond;
            pc        <= pc_in;
        end
    end

    // Sticky halt: set when a HALT actually issues (a coincident flush squashes it).
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            halted <= 1'b0;
        else if (issue && cls == CLS_HALT)
            halted <= 1'b1;
    end

endmodule

// File: tb/tb_operand_fetch_unit.sv
// Directed bench for operand_fetch_unit: reset, bypasses, stalls, flush, halt and mid-stream reset.
// Inputs change on the falling edge; registered outputs are sampled 1 time unit after the rising edge.
// Works with or without OPERAND_FORWARD_EN; expected operand values are identical in both builds.
module tb_operand_fetch_unit;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] instruction = '0;
    logic [9:0]  pc_in = '0;
    logic        flush = 1'b0;
    logic [2:0]  ex_dest = '0;
    logic [15:0] ex_result = '0;
    logic        ex_wb_reg = 1'b0;
    logic        ex_read = 1'b0;
    logic        wb_en = 1'b0;
    logic [2:0]  wb_dest = '0;
    logic [15:0] wb_data = '0;
    logic        out_valid;
    logic [6:0]  opcode;
    logic [2:0]  dest;
    logic [15:0] operand0, operand1, operand2;
    logic [3:0]  value;
    logic [7:0]  constant;
    logic [9:0]  offset;
    logic [2:0]  condition;
    logic [9:0]  pc;
    logic        halted;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clock = ~clock;

    operand_fetch_unit dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .instruction(instruction), .pc_in(pc_in), .flush(flush),
        .ex_dest(ex_dest), .ex_result(ex_result), .ex_wb_reg(ex_wb_reg), .ex_read(ex_read),
        .wb_en(wb_en), .wb_dest(wb_dest), .wb_data(wb_data),
        .out_valid(out_valid), .opcode(opcode), .dest(dest),
        .operand0(operand0), .operand1(operand1), .operand2(operand2),
        .value(value), .constant(constant), .offset(offset), .condition(condition),
        .pc(pc), .halted(halted)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [6:0] op, input logic [2:0] cnd,
                                       input logic [2:0] a, input logic [2:0] b,
                                       input logic [2:0] c, input logic [9:0] off);
        return {op, cnd, a, b, c, 3'b000, off};
    endfunction

    task automatic drive(input logic v, input logic [31:0] ins, input logic [9:0] p);
        @(negedge clock);
        in_valid    = v;
        instruction = ins;
        pc_in       = p;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        // Reset state
        #12;
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_opcode", opcode, 0);
        check_eq("rst_halted", halted, 0);
        check_eq("rst_pc", pc, 0);
        @(negedge clock);
        reset = 1'b1;
        #1 check_eq("rst_in_ready", in_ready, 1);

        // Write r3 through writeback, then ARITH r0=2 r1=3 r2=3
        @(negedge clock);
        wb_en = 1; wb_dest = 3; wb_data = 16'h1234;
        tick();
        drive(1, mk(7'h10, 3'd5, 3'd2, 3'd3, 3'd3, 10'h2A5), 10'h040);
        wb_en = 0;
        #1 check_eq("arith_in_ready", in_ready, 1);
        tick();
        check_eq("arith_out_valid", out_valid, 1);
        check_eq("arith_opcode", opcode, 7'h10);
        check_eq("arith_dest", dest, 2);
        check_eq("arith_op1", operand1, 16'h1234);
        check_eq("arith_op2", operand2, 16'h1234);
        check_eq("arith_op0_unused", operand0, 16'h0000);
        check_eq("arith_offset", offset, 10'h2A5);
        check_eq("arith_constant", constant, 8'hA5);
        check_eq("arith_value", value, 4'h5);
        check_eq("arith_cond", condition, 3'd5);
        check_eq("arith_pc", pc, 10'h040);

        // Execute producer on r1=5 with coincident writeback of r5
        drive(1, mk(7'h11, 3'd0, 3'd1, 3'd5, 3'd0, 10'h000), 10'h041);
        ex_wb_reg = 1; ex_dest = 5; ex_result = 16'hBEEF;
        wb_en = 1; wb_dest = 5; wb_data = 16'h0001;
`ifdef OPERAND_FORWARD_EN
        #1 check_eq("fwd_in_ready", in_ready, 1);
        tick();
`else
        #1 check_eq("nofwd_stall_ready", in_ready, 0);
        tick();
        check_eq("nofwd_bubble", out_valid, 0);
        @(negedge clock);
        ex_wb_reg = 0; wb_en = 1; wb_dest = 5; wb_data = 16'hBEEF;
        #1 check_eq("nofwd_in_ready", in_ready, 1);
        tick();
`endif
        check_eq("fwd_out_valid", out_valid, 1);
        check_eq("fwd_op1", operand1, 16'hBEEF);
        check_eq("fwd_op2_r0", operand2, 16'h0000);

        // Load-use on r2=4 for a LOGIC instruction
        drive(1, mk(7'h20, 3'd0, 3'd3, 3'd1, 3'd4, 10'h000), 10'h042);
        ex_wb_reg = 0; wb_en = 0; ex_read = 1; ex_dest = 4;
        #1 check_eq("lu_in_ready", in_ready, 0);
        tick();
        check_eq("lu_bubble_valid", out_valid, 0);
        check_eq("lu_bubble_opcode", opcode, 0);
        @(negedge clock);
        ex_read = 0; wb_en = 1; wb_dest = 4; wb_data = 16'h00AA;
        #1 check_eq("lu_release_ready", in_ready, 1);
        tick();
        check_eq("lu_issue_valid", out_valid, 1);
        check_eq("lu_issue_opcode", opcode, 7'h20);
        check_eq("lu_issue_op2", operand2, 16'h00AA);

        // SHIFT does not use r2, so a load to r4 must not stall; r2 output still driven from GPR
        drive(1, mk(7'h30, 3'd0, 3'd0, 3'd1, 3'd4, 10'h003), 10'h043);
        wb_en = 0; ex_read = 1; ex_dest = 4;
        #1 check_eq("shift_in_ready", in_ready, 1);
        tick();
        check_eq("shift_valid", out_valid, 1);
        check_eq("shift_op2_unused", operand2, 16'h00AA);

        // Flush with a valid instruction, then flush with a coincident load-use stall
        drive(1, mk(7'h10, 3'd0, 3'd2, 3'd3, 3'd3, 10'h000), 10'h044);
        ex_read = 0; flush = 1;
        tick();
        check_eq("flush_valid", out_valid, 0);
        check_eq("flush_opcode", opcode, 0);
        drive(1, mk(7'h20, 3'd0, 3'd3, 3'd4, 3'd1, 10'h000), 10'h045);
        ex_read = 1; ex_dest = 4;
        #1 check_eq("flush_lu_ready", in_ready, 1);
        tick();
        check_eq("flush_lu_valid", out_valid, 0);

        // Reset mid-stream while out_valid=1
        drive(1, mk(7'h10, 3'd0, 3'd2, 3'd3, 3'd3, 10'h000), 10'h055);
        flush = 0; ex_read = 0;
        tick();
        check_eq("mid_pre_valid", out_valid, 1);
        #2 reset = 0;
        #1;
        check_eq("mid_rst_valid", out_valid, 0);
        check_eq("mid_rst_opcode", opcode, 0);
        check_eq("mid_rst_op1", operand1, 0);
        check_eq("mid_rst_pc", pc, 0);
        drive(0, 32'h0, 10'h0);
        reset = 1;
        drive(1, mk(7'h10, 3'd0, 3'd2, 3'd3, 3'd3, 10'h000), 10'h056);
        tick();
        check_eq("post_rst_valid", out_valid, 1);
        check_eq("post_rst_r3", operand1, 16'h0000);

        // HALT with coincident flush is squashed
        drive(1, mk(7'h70, 3'd0, 3'd0, 3'd0, 3'd0, 10'h000), 10'h060);
        flush = 1;
        tick();
        check_eq("halt_flush_halted", halted, 0);
        check_eq("halt_flush_valid", out_valid, 0);

        // HALT issues, then stage refuses new work
        drive(1, mk(7'h70, 3'd0, 3'd0, 3'd0, 3'd0, 10'h000), 10'h061);
        flush = 0;
        #1 check_eq("halt_in_ready", in_ready, 1);
        tick();
        check_eq("halt_halted", halted, 1);
        check_eq("halt_valid", out_valid, 1);
        check_eq("halt_opcode", opcode, 7'h70);
        drive(1, mk(7'h10, 3'd0, 3'd2, 3'd3, 3'd3, 10'h000), 10'h062);
        #1 check_eq("post_halt_ready", in_ready, 0);
        tick();
        check_eq("post_halt_valid", out_valid, 0);
        check_eq("post_halt_opcode", opcode, 0);
        tick();
        check_eq("post_halt_sticky", halted, 1);
        check_eq("post_halt_valid2", out_valid, 0);

        // Reset clears halt
        @(negedge clock);
        in_valid = 0;
        reset = 0;
        #1 check_eq("halt_rst_halted", halted, 0);
        @(negedge clock);
        reset = 1;
        #1 check_eq("halt_rst_ready", in_ready, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/operand_fetch_unit.md
Name: operand_fetch_unit

Overview:
- Decode/operand-read pipeline stage, sits directly upstream of the execute stage.
- Takes a 32-bit instruction from fetch, decodes the register fields and reads an internal 8-entry general-purpose register file.
- Resolves read-after-write hazards by forwarding or stalling, then registers the opcode, operands and immediate fields for execute.
- Owns the register file write port driven by the writeback stage.

Parameters:
DATA_WIDTH, 16, width of GPRs and operands
ADDR_WIDTH, 10, PC width
GPR_COUNT, 8, number of registers (index width = clog2 = 3)

Ports:
clock  input  1  stage clock
reset  input  1  asynchronous, active-low
in_valid  input  1  fetch presents instruction
in_ready  output  1  stage accepts instruction this cycle
instruction  input  32  opcode[31:25] cond[24:22] r0[21:19] r1[18:16] r2[15:13] offset[9:0] constant[7:0] value[3:0]
pc_in  input  ADDR_WIDTH  PC of instruction
flush  input  1  execute jump taken; squash this stage
ex_dest  input  3  register index targeted by instruction now in execute
ex_result  input  DATA_WIDTH  execute combinational result
ex_wb_reg  input  1  execute instruction writes register from ALU (WB_REGISTER)
ex_read  input  1  execute instruction is LOAD (WB_MEMORY)
wb_en  input  1  writeback writes register file
wb_dest  input  3  writeback register index
wb_data  input  DATA_WIDTH  writeback data
out_valid  output  1  execute-side registers hold a real instruction
opcode  output  7  registered opcode (7'h00 = NOP when bubble)
dest  output  3  registered r0 index
operand0/1/2  output  DATA_WIDTH each  registered values of r0/r1/r2
value  output  4, constant  output  8, offset  output  10, condition  output  3, pc  output  ADDR_WIDTH  registered fields
halted  output  1  sticky, HALT has been issued

Behaviour:
- Class = opcode[6:4]: 000 NOP, 001 ARITH, 010 LOGIC, 011 SHIFT, 100 MEM, 101 JUMP, 110 JUMP_COND, 111 HALT.
- Sources used: ARITH/LOGIC r1,r2; SHIFT r1; MEM r0,r1 (LOADC reads r0 for upper bits); JUMP r0; JUMP_COND r0,r1; NOP/HALT none.
- Operand select, per used source, highest priority first:
  - (ex_wb_reg && ex_dest==idx) -> ex_result
  - (wb_en && wb_dest==idx) -> wb_data
  - register file.
- Unused source outputs are still driven with their selected value.
- Register file write: synchronous on clock when wb_en. Same-cycle read of the same index gets wb_data via the bypass.
- Load-use hazard: in_valid && ex_read && a used source == ex_dest.
  - in_ready=0; output registers load a bubble (opcode 0, out_valid 0); the instruction is held by fetch.
  - Exactly 1 stall cycle, because the LOAD leaves execute on the next cycle.
- Latency: 1 cycle from accept (in_valid && in_ready) to out_valid.
- flush: highest priority. Next cycle outputs a bubble; any accepted instruction is discarded. in_ready=1 during flush, so fetch may drop its instruction.
- HALT accepted: issued normally. halted sets on the same edge; afterwards in_ready=0 and only bubbles are emitted.
  - flush coincident with HALT acceptance: HALT is squashed and halted stays 0.
- in_valid=0: bubble.
- Reset (async, any time):
  - All output registers 0: opcode 0, out_valid 0, operands 0, pc 0.
  - halted 0; all GPRs 0.
  - in_ready becomes 1 combinationally once reset is deasserted.

Optional Feature:
OPERAND_FORWARD_EN
- Defined: execute-to-operand forwarding (ex_result path) as above.
- Undefined: no ex_result path. Any used source equal to ex_dest while ex_wb_reg or ex_read is set stalls 1 cycle, same as load-use. The writeback bypass remains.

Test Plan:
- Reset, write r3=16'h1234 via wb, then ARITH r0=2 r1=3 r2=3 -> next cycle operand1=operand2=16'h1234, dest=2, out_valid=1.
- ARITH with r1=5 while ex_wb_reg=1 ex_dest=5 ex_result=16'hBEEF and wb writing r5=16'h0001 -> operand1=16'hBEEF. Without OPERAND_FORWARD_EN: one bubble, then the operand equals the later wb value.
- ex_read=1 ex_dest=4, incoming LOGIC using r2=4 -> in_ready=0 for 1 cycle, bubble out, instruction issued the following cycle.
- flush=1 with in_valid=1 -> next cycle opcode=0, out_valid=0. Flush with coincident load-use stall -> still a bubble, in_ready=1.
- HALT (opcode 7'h70) accepted -> halted=1 next edge, in_ready=0 thereafter, all later outputs bubbles until reset.
- Assert reset mid-stream with out_valid=1 -> outputs and GPRs read 0 immediately; r3 reads 0 after release.
